// File: rtl/encrypt_pkg.sv
// encrypt_pkg: shared definitions for the iterative 64-bit SP block cipher.
//   - SBOX        : 4-bit substitution table
//   - ROUNDS_DEF  : default number of SP rounds
//   - fsm_e       : control FSM states (IDLE, RUN, FINAL)
//   - sbox4 / s_layer / p_layer / key_update : golden round primitives
package encrypt_pkg;

  localparam int ROUNDS_DEF = 10;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {IDLE, RUN, FINAL} fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
    return y;
  endfunction

  // Bit 4j+k lands on j+16k; bit 63 maps onto itself under this form.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 4; k++)
        y[j + 16*k] = x[4*j + k];
    return y;
  endfunction

  // End-of-round key schedule: rotl 13, S-box the top nibble, mix in round index.
  function automatic logic [63:0] key_update(input logic [63:0] k, input logic [3:0] r);
    logic [63:0] t;
    t          = {k[50:0], k[63:51]};
    t[63:60]   = sbox4(t[63:60]);
    t[4:0]     = t[4:0] ^ {1'b0, r};
    return t;
  endfunction

endpackage

// File: rtl/encrypt_if.sv
// encrypt_if: start/done handshake and data bus of the encrypt core.
//   master : system controller (drives start/plaintext/secretKey)
//   slave  : encrypt core (drives busy/done/ciphertext)
// With ENCRYPT_DBG_EN defined, dbg_state/dbg_round are also carried.
interface encrypt_if;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] secretKey;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;
`ifdef ENCRYPT_DBG_EN
  logic [63:0] dbg_state;
  logic [3:0]  dbg_round;

  modport master (output start, plaintext, secretKey,
                  input  busy, done, ciphertext, dbg_state, dbg_round);
  modport slave  (input  start, plaintext, secretKey,
                  output busy, done, ciphertext, dbg_state, dbg_round);
`else
  modport master (output start, plaintext, secretKey,
                  input  busy, done, ciphertext);
  modport slave  (input  start, plaintext, secretKey,
                  output busy, done, ciphertext);
`endif
endinterface

// File: rtl/encrypt_round.sv
// encrypt_round: one combinational SP round.
//   state_i/key_i : current state and round key
//   r_i           : round index mixed into the key schedule
//   state_o       : P(S(state ^ key))
//   key_o         : key_update(key, r)
module encrypt_round
  import encrypt_pkg::*;
(
  input  logic [63:0] state_i,
  input  logic [63:0] key_i,
  input  logic [3:0]  r_i,
  output logic [63:0] state_o,
  output logic [63:0] key_o
);
  assign state_o = p_layer(s_layer(state_i ^ key_i));
  assign key_o   = key_update(key_i, r_i);
endmodule

// File: rtl/encrypt.sv
// encrypt: iterative 64-bit block cipher, one SP round per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : encrypt_if.slave (start/plaintext/secretKey in; busy/done/ciphertext out)
// Optional: ENCRYPT_DBG_EN exposes dbg_state/dbg_round on the interface.
// Timing: start at E0, rounds at E1..E{ROUNDS}, ciphertext+done at E{ROUNDS+1}.
module encrypt
  import encrypt_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  encrypt_if.slave bus
);

  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("encrypt: ROUNDS must be in 1..15");
  end

  localparam logic [3:0] LAST = 4'(ROUNDS);

  fsm_e        fsm_q,   fsm_d;
  logic [63:0] state_q, state_d;
  logic [63:0] key_q,   key_d;
  logic [3:0]  round_q, round_d;
  logic [63:0] ct_q,    ct_d;
  logic        done_q,  done_d;

  logic [63:0] rnd_state, rnd_key;

  encrypt_round u_round (
    .state_i (state_q),
    .key_i   (key_q),
    .r_i     (round_q),
    .state_o (rnd_state),
    .key_o   (rnd_key)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      // done is high while IDLE, so a start in the done cycle is accepted.
      IDLE: if (bus.start) begin
        state_d = bus.plaintext;
        key_d   = bus.secretKey;
        round_d = 4'd1;
        fsm_d   = RUN;
      end
      RUN: begin
        state_d = rnd_state;
        key_d   = rnd_key;
        round_d = round_q + 4'd1;
        if (round_q == LAST) fsm_d = FINAL;
      end
      FINAL: begin
        ct_d   = state_q ^ key_q;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.busy       = (fsm_q != IDLE);
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;
`ifdef ENCRYPT_DBG_EN
  assign bus.dbg_state  = state_q;
  assign bus.dbg_round  = round_q;
`endif

endmodule

// File: tb/tb_encrypt.sv
// tb_encrypt: directed self-checking bench for encrypt with a ciphertext scoreboard.
module tb_encrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encrypt_if bus ();

  encrypt #(.ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  // Independent reference model, written from the algorithm description.
  logic [3:0] tsb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [63:0] k0);
    logic [63:0] s, k, x, y;
    s = pt;
    k = k0;
    for (int r = 1; r <= 10; r++) begin
      x = s ^ k;
      for (int n = 0; n < 16; n++) x[4*n +: 4] = tsb[x[4*n +: 4]];
      y = '0;
      for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
      y[63] = x[63];
      s = y;
      k = (k << 13) | (k >> 51);
      k[63:60] = tsb[k[63:60]];
      k[4:0] = k[4:0] ^ 5'(r);
    end
    return s ^ k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.ciphertext, e);
    end
  endtask

  // Called at the sample just after the start edge (sample 0). Returns at the
  // sample where done is seen (done_at) or -1 after a bounded wait.
  task automatic wait_done(input int lock_at, input bit chk_held, input logic [63:0] held_ct,
                           output int done_at, output int busy_cnt, output int held_bad);
    done_at = -1; busy_cnt = 0; held_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == lock_at) begin
        bus.start = 1'b1;
        bus.plaintext = 64'hFEDCBA9876543210;
      end else if (k == lock_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (chk_held && bus.done !== 1'b1 && bus.ciphertext !== held_ct) held_bad++;
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
      step();
    end
  endtask

  task automatic launch(input logic [63:0] pt, input logic [63:0] key);
    bus.plaintext = pt;
    bus.secretKey = key;
    bus.start = 1'b1;
    exp_q.push_back(m_enc(pt, key));
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int da, bc, hb, dcnt;
    logic [63:0] res1, first;
    bus.start = 1'b0;
    bus.plaintext = '0;
    bus.secretKey = '0;

    // Reset
    rst_n = 1'b0;
    step(); step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ct", bus.ciphertext, 64'd0);
`ifdef ENCRYPT_DBG_EN
    chk("rst_dbg_round", 64'(bus.dbg_round), 64'd0);
`endif
    rst_n = 1'b1;
    step();

`ifdef ENCRYPT_DBG_EN
    // Load and first round with all-zero operands
    launch(64'd0, 64'd0);
    chk("dbg_load_state", bus.dbg_state, 64'd0);
    chk("dbg_load_round", 64'(bus.dbg_round), 64'd1);
    step();
    chk("dbg_r1_state", bus.dbg_state, 64'hFFFFFFFF00000000);
    wait_done(-1, 1'b0, 64'd0, da, bc, hb);
    pop_chk("dbg_zero_ct");
    step();
`endif

    // Latency
    launch(64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978);
    wait_done(-1, 1'b0, 64'd0, da, bc, hb);
    chk("lat_done_at", 64'(da), 64'd11);
    chk("lat_busy_cnt", 64'(bc), 64'd11);
    res1 = bus.ciphertext;
    pop_chk("lat_ct");
    step();
    chk("lat_done_pulse", 64'(bus.done), 64'd0);
    chk("lat_busy_low", 64'(bus.busy), 64'd0);

    // Busy lockout: second start at E5 must be ignored
    launch(64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978);
    wait_done(4, 1'b0, 64'd0, da, bc, hb);
    chk("lock_done_at", 64'(da), 64'd11);
    chk("lock_ct_same", bus.ciphertext, res1);
    pop_chk("lock_ct");
    step();

    // Back-to-back: new start in the done cycle
    launch(64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978);
    wait_done(-1, 1'b0, 64'd0, da, bc, hb);
    first = bus.ciphertext;
    pop_chk("b2b_first_ct");
    launch(64'h1122334455667788, 64'hAABBCCDDEEFF0011);
    wait_done(-1, 1'b1, first, da, bc, hb);
    chk("b2b_gap", 64'(da + 1), 64'd12);
    chk("b2b_held", 64'(hb), 64'd0);
    pop_chk("b2b_second_ct");
    step();

    // Random blocks
    for (int n = 0; n < 3; n++) begin
      launch({$urandom, $urandom}, {$urandom, $urandom});
      wait_done(-1, 1'b0, 64'd0, da, bc, hb);
      chk("rnd_done_at", 64'(da), 64'd11);
      pop_chk("rnd_ct");
      step();
    end

    // Mid-run reset at E4: block discarded, no done
    launch(64'hDEADBEEFCAFEF00D, 64'h0011223344556677);
    void'(exp_q.pop_back());
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_ct", bus.ciphertext, 64'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done === 1'b1) dcnt++;
      step();
    end
    chk("mrst_no_done", 64'(dcnt), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
